frame_aligner: RTL and testbench

- Word-boundary aligner directly downstream of the 40-bit deserializer, clocked by the deserializer word clock.
- Deserialized words carry an arbitrary bit rotation. This block finds the rotation by searching for a frame header (sync pattern) that recurs every FRAME_LEN words.
- It declares lock after repeated hits and then outputs re-aligned words with a start-of-frame flag.
- While locked it monitors header integrity and counts header misses.

---
 rtl/frame_aligner.sv | 229 ++++++++++++++++++++++
 tb/tb_frame_aligner.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_aligner.sv
// frame_aligner
//   Word-boundary aligner that sits directly behind a deserializer and runs on
//   its word clock. Incoming words carry an unknown bit rotation. The block
//   slides a WORDWIDTH-bit window across two consecutive words, hunting for a
//   SYNC_PATTERN header that recurs every FRAME_LEN words. Once LOCK_HITS
//   on-time headers have been seen it declares lock. It then outputs re-aligned
//   words with a start-of-frame flag and counts header misses.
//
// Ports
//   clk       in   word clock
//   reset     in   asynchronous, active-low reset
//   din       in   [WORDWIDTH-1:0] deserialized word, MSB is the earliest bit
//   realign   in   pulse: abandon current alignment, resume search at next slip
//   clr_err   in   synchronous clear of err_cnt (wins over an increment)
//   dout      out  [WORDWIDTH-1:0] aligned word, one clock after its window
//   sof       out  dout sits at an expected header position (locked only)
//   locked    out  aligner is in the LOCKED state
//   slip      out  [SLIPWIDTH-1:0] current bit offset, 0..WORDWIDTH-1
//   err_cnt   out  [15:0] saturating count of header misses while locked
//   state_dbg out  [1:0] FSM state for observation: 0 SEARCH, 1 VERIFY, 2 LOCKED
//
// This block has no valid/ready handshake: a new word is accepted on every
// clock and an aligned word is produced on every clock.

module frame_aligner #(
    parameter int                  WORDWIDTH     = 40,
    parameter int                  SLIPWIDTH     = 6,
    parameter int                  SYNCWIDTH     = 16,
    parameter logic [SYNCWIDTH-1:0] SYNC_PATTERN = 16'hF0A5,
    parameter int                  FRAME_LEN     = 8,
    parameter int                  LOCK_HITS     = 3,
    parameter int                  UNLOCK_MISSES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 realign,
    input  logic                 clr_err,
    output logic [WORDWIDTH-1:0] dout,
    output logic                 sof,
    output logic                 locked,
    output logic [SLIPWIDTH-1:0] slip,
    output logic [15:0]          err_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]           LAST_POS    = 8'(FRAME_LEN - 1);
    localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_HITS);
    localparam logic [3:0]           MISS_LIMIT  = 4'(UNLOCK_MISSES);
    localparam logic [SLIPWIDTH-1:0] LAST_SLIP   = SLIPWIDTH'(WORDWIDTH - 1);

    state_t                 state, state_next;
    logic [WORDWIDTH-1:0]   prev_word;
    logic [7:0]             wcnt, wcnt_next;
    logic [7:0]             frame_pos, frame_pos_next;
    logic [3:0]             hit_cnt, hit_cnt_next;
    logic [3:0]             miss_cnt, miss_cnt_next;
    logic [SLIPWIDTH-1:0]   slip_next;
    logic [15:0]            err_next;
    logic                   err_inc;
    logic                   sof_next;

    // ------------------------------------------------------------------
    // Datapath: window selection and header detection
    // ------------------------------------------------------------------
    logic [2*WORDWIDTH-1:0] cat;
    logic [2*WORDWIDTH-1:0] shifted;
    logic [WORDWIDTH-1:0]   window;
    logic                   hit;
    logic [SLIPWIDTH-1:0]   slip_adv;
    logic [7:0]             frame_pos_inc;

    // Shifting left by slip and keeping the upper half is the same as taking
    // cat[2*WORDWIDTH-1-slip -: WORDWIDTH]; slip=0 selects prev_word.
    assign cat     = {prev_word, din};
    assign shifted = cat << slip;
    assign window  = shifted[2*WORDWIDTH-1 -: WORDWIDTH];
    assign hit     = (window[WORDWIDTH-1 -: SYNCWIDTH] == SYNC_PATTERN);

    assign slip_adv      = (slip == LAST_SLIP) ? '0 : slip + 1'b1;
    assign frame_pos_inc = (frame_pos == LAST_POS) ? 8'd0 : frame_pos + 8'd1;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and counter updates
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        slip_next      = slip;
        wcnt_next      = wcnt;
        frame_pos_next = frame_pos;
        hit_cnt_next   = hit_cnt;
        miss_cnt_next  = miss_cnt;
        err_inc        = 1'b0;

        if (realign) begin
            // Forced re-search overrides whatever the current state decided.
            state_next     = SEARCH;
            slip_next      = slip_adv;
            wcnt_next      = 8'd0;
            hit_cnt_next   = 4'd0;
            miss_cnt_next  = 4'd0;
            frame_pos_next = 8'd0;
        end else begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        // The hit word is frame position 0, so the next one is 1.
                        state_next     = VERIFY;
                        frame_pos_next = 8'd1;
                        hit_cnt_next   = 4'd1;
                    end else if (wcnt == LAST_POS) begin
                        // A whole frame seen at this offset without a header.
                        slip_next = slip_adv;
                        wcnt_next = 8'd0;
                    end else begin
                        wcnt_next = wcnt + 8'd1;
                    end
                end

                VERIFY: begin
                    frame_pos_next = frame_pos_inc;
                    if (frame_pos == 8'd0) begin
                        if (hit) begin
                            hit_cnt_next = hit_cnt + 4'd1;
                            if (hit_cnt_next == LOCK_TARGET) begin
                                state_next    = LOCKED;
                                miss_cnt_next = 4'd0;
                            end
                        end else begin
                            state_next     = SEARCH;
                            slip_next      = slip_adv;
                            wcnt_next      = 8'd0;
                            hit_cnt_next   = 4'd0;
                            frame_pos_next = 8'd0;
                        end
                    end
                end

                LOCKED: begin
                    frame_pos_next = frame_pos_inc;
                    if (frame_pos == 8'd0) begin
                        if (hit) begin
                            miss_cnt_next = 4'd0;
                        end else begin
                            miss_cnt_next = miss_cnt + 4'd1;
                            err_inc       = 1'b1;
                            if (miss_cnt_next == MISS_LIMIT) begin
                                // Keep the offset: the link most likely
                                // glitched rather than changed rotation.
                                state_next     = SEARCH;
                                wcnt_next      = 8'd0;
                                miss_cnt_next  = 4'd0;
                                frame_pos_next = 8'd0;
                            end
                        end
                    end
                end

                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs derived from the current state
    // ------------------------------------------------------------------
    always_comb begin
        sof_next  = (state == LOCKED) && (frame_pos == 8'd0);
        locked    = (state == LOCKED);
        state_dbg = state;
    end

    // Saturating error counter; a clear in the same cycle beats an increment.
    always_comb begin
        err_next = err_cnt;
        if (clr_err) begin
            err_next = 16'd0;
        end else if (err_inc && (err_cnt != 16'hFFFF)) begin
            err_next = err_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_word <= '0;
            dout      <= '0;
            sof       <= 1'b0;
            slip      <= '0;
            wcnt      <= 8'd0;
            frame_pos <= 8'd0;
            hit_cnt   <= 4'd0;
            miss_cnt  <= 4'd0;
            err_cnt   <= 16'd0;
        end else begin
            prev_word <= din;
            dout      <= window;
            sof       <= sof_next;
            slip      <= slip_next;
            wcnt      <= wcnt_next;
            frame_pos <= frame_pos_next;
            hit_cnt   <= hit_cnt_next;
            miss_cnt  <= miss_cnt_next;
            err_cnt   <= err_next;
        end
    end

endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner
//   Directed bench for frame_aligner. A transmit stream (header every 8 words,
//   PRBS7 filler) is rotated by a chosen bit offset and fed in word by word.
//   A behavioural model, driven by the same inputs, predicts every output on
//   every cycle; literal checks pin the lock/sof/err timing of each scenario.

module tb_frame_aligner;

    localparam int W      = 40;
    localparam int FL     = 8;
    localparam int NWORDS = 1024;
    localparam int LOCK_HITS     = 3;
    localparam int UNLOCK_MISSES = 4;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         realign = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] dout;
    logic         sof;
    logic         locked;
    logic [5:0]   slip;
    logic [15:0]  err_cnt;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    frame_aligner dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .realign   (realign),
        .clr_err   (clr_err),
        .dout      (dout),
        .sof       (sof),
        .locked    (locked),
        .slip      (slip),
        .err_cnt   (err_cnt),
        .state_dbg (state_dbg)
    );

    // ------------------------------------------------------------------
    // Stream generation
    // ------------------------------------------------------------------
    logic [W-1:0] tx_mem [NWORDS];
    bit           corrupt_frame [NWORDS/FL];
    int           rot;
    int           k;

    function automatic logic [W-1:0] tx_eff(input int n);
        logic [W-1:0] w;
        if (n < 0 || n >= NWORDS) return '0;
        w = tx_mem[n];
        if ((n % FL) == 0 && corrupt_frame[n/FL]) w[W-1 -: 16] = 16'h0F5A;
        return w;
    endfunction

    // Received word n: the transmitted bitstream delayed by rot bits.
    function automatic logic [W-1:0] rx_word(input int n);
        logic [2*W-1:0] pair;
        pair = {tx_eff(n-1), tx_eff(n)};
        pair = pair >> rot;
        return pair[W-1:0];
    endfunction

    task automatic build_stream();
        logic [6:0]   lfsr;
        logic [W-1:0] w;
        logic         b;
        lfsr = 7'h7F;
        for (int n = 0; n < NWORDS; n++) begin
            for (int i = W-1; i >= 0; i--) begin
                b = lfsr[6] ^ lfsr[5];
                lfsr = {lfsr[5:0], b};
                w[i] = b;
            end
            if ((n % FL) == 0) w[W-1 -: 16] = 16'hF0A5;
            tx_mem[n] = w;
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard counters and check
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tracks the frame phase as an anchor cycle and the
    // per-offset dwell as a start cycle, rather than with running counters.
    // ------------------------------------------------------------------
    int           m_mode;     // 0 search, 1 verify, 2 locked
    int           m_slip, m_hits, m_misses, m_err;
    int           m_cyc, m_anchor, m_slip_start;
    logic [W-1:0] m_prev, m_dout;
    bit           m_sof;

    task automatic model_reset();
        m_mode = 0; m_slip = 0; m_hits = 0; m_misses = 0; m_err = 0;
        m_cyc = 0; m_anchor = 0; m_slip_start = 0;
        m_prev = '0; m_dout = '0; m_sof = 0;
    endtask

    task automatic model_step();
        logic [2*W-1:0] cat;
        logic [W-1:0]   win;
        bit             hit, on_time;
        int             next_slip;
        cat = {m_prev, din};
        for (int b = 0; b < W; b++) win[W-1-b] = cat[2*W-1-m_slip-b];
        hit       = (win[W-1 -: 16] == 16'hF0A5);
        on_time   = ((m_cyc - m_anchor) % FL) == 0;
        next_slip = (m_slip + 1) % W;
        m_sof  = (m_mode == 2) && on_time;
        m_dout = win;
        m_prev = din;
        if (realign) begin
            m_mode = 0; m_slip = next_slip; m_slip_start = m_cyc + 1;
            m_hits = 0; m_misses = 0;
        end else if (m_mode == 0) begin
            if (hit) begin
                m_mode = 1; m_anchor = m_cyc; m_hits = 1;
            end else if (m_cyc - m_slip_start == FL - 1) begin
                m_slip = next_slip; m_slip_start = m_cyc + 1;
            end
        end else if (on_time) begin
            if (m_mode == 1) begin
                if (hit) begin
                    m_hits++;
                    if (m_hits == LOCK_HITS) begin m_mode = 2; m_misses = 0; end
                end else begin
                    m_mode = 0; m_slip = next_slip; m_slip_start = m_cyc + 1; m_hits = 0;
                end
            end else begin
                if (hit) m_misses = 0;
                else begin
                    m_misses++;
                    if (m_err < 65535) m_err++;
                    if (m_misses == UNLOCK_MISSES) begin
                        m_mode = 0; m_slip_start = m_cyc + 1; m_misses = 0;
                    end
                end
            end
        end
        if (clr_err) m_err = 0;
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // Compare process: outputs only move on posedge or reset, so negedge is safe.
    initial begin
        forever begin
            @(negedge clk);
            check("dout",      64'(dout),      64'(m_dout));
            check("sof",       64'(sof),       64'(m_sof));
            check("locked",    64'(locked),    64'(m_mode == 2));
            check("slip",      64'(slip),      64'(m_slip));
            check("err_cnt",   64'(err_cnt),   64'(m_err));
            check("state_dbg", 64'(state_dbg), 64'(m_mode));
            check("slip_range", 64'(slip < 6'd40), 64'd1);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input bit ra, input bit ce);
        din = rx_word(k); realign = ra; clr_err = ce;
        @(posedge clk); #1;
        realign = 1'b0; clr_err = 1'b0;
        k++;
    endtask

    // After this returns, the edge that captured word j has happened.
    task automatic run_to(input int j);
        while (k <= j) drive(1'b0, 1'b0);
    endtask

    task automatic run_until_locked(input int budget, input string name);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            drive(1'b0, 1'b0);
            n++;
        end
        check(name, 64'(locked), 64'd1);
    endtask

    task automatic start_test(input int r);
        @(posedge clk); #1;
        reset = 1'b0; din = '0; realign = 1'b0; clr_err = 1'b0;
        rot = r; k = 0;
        foreach (corrupt_frame[i]) corrupt_frame[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        build_stream();
        rot = 0; k = 0;
        foreach (corrupt_frame[i]) corrupt_frame[i] = 1'b0;

        // Aligned stream: headers at words 0, 8, 16 -> lock on edge of word 17.
        start_test(0);
        check("rst_dout",   64'(dout),    64'd0);
        check("rst_sof",    64'(sof),     64'd0);
        check("rst_locked", 64'(locked),  64'd0);
        check("rst_slip",   64'(slip),    64'd0);
        check("rst_err",    64'(err_cnt), 64'd0);
        run_to(16);
        check("aligned_not_locked_yet", 64'(locked), 64'd0);
        run_to(17);
        check("aligned_locked",  64'(locked),  64'd1);
        check("aligned_slip",    64'(slip),    64'd0);
        check("aligned_err",     64'(err_cnt), 64'd0);
        run_to(24);
        check("aligned_sof_off", 64'(sof), 64'd0);
        for (int f = 3; f <= 5; f++) begin
            run_to(f*FL + 1);
            check("aligned_sof",    64'(sof),             64'd1);
            check("aligned_header", 64'(dout[W-1 -: 16]), 64'h0000_0000_0000_F0A5);
            check("aligned_word",   64'(dout),            64'(tx_eff(f*FL)));
        end

        // Rotated by 13: slip 13 reached at word 104, lock on word 121.
        start_test(13);
        run_until_locked(130, "rot13_lock_in_130");
        check("rot13_slip", 64'(slip), 64'd13);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
            check("rot13_dout", 64'(dout), 64'(tx_eff(k-2)));
        end

        // Rotated by 39: the search walks the whole range before locking.
        start_test(39);
        run_until_locked(400, "rot39_lock");
        check("rot39_slip", 64'(slip), 64'd39);

        // Header corruption while locked.
        start_test(0);
        corrupt_frame[4] = 1'b1; corrupt_frame[5] = 1'b1; corrupt_frame[6] = 1'b1;
        corrupt_frame[8] = 1'b1; corrupt_frame[9] = 1'b1;
        corrupt_frame[10] = 1'b1; corrupt_frame[11] = 1'b1;
        corrupt_frame[15] = 1'b1;
        run_to(57);
        check("miss3_locked", 64'(locked),  64'd1);
        check("miss3_err",    64'(err_cnt), 64'd3);
        run_to(88);
        check("miss7_still_locked", 64'(locked),  64'd1);
        check("miss6_err",          64'(err_cnt), 64'd6);
        run_to(89);
        check("miss4_unlocked", 64'(locked),  64'd0);
        check("miss4_err",      64'(err_cnt), 64'd7);
        check("miss4_slip",     64'(slip),    64'd0);
        run_to(113);
        check("relock_after_miss", 64'(locked), 64'd1);
        run_to(120);
        drive(1'b0, 1'b1);
        check("clr_err_wins", 64'(err_cnt), 64'd0);
        check("clr_err_locked", 64'(locked), 64'd1);

        // Realign while locked at offset 5, then mid-lock asynchronous reset.
        start_test(5);
        run_until_locked(100, "rot5_lock");
        check("rot5_slip", 64'(slip), 64'd5);
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        check("realign_unlocked", 64'(locked), 64'd0);
        check("realign_slip",     64'(slip),   64'd6);
        run_until_locked(400, "realign_relock");
        check("realign_relock_slip", 64'(slip), 64'd5);
        repeat (2) drive(1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_dout",   64'(dout),   64'd0);
        check("async_rst_slip",   64'(slip),   64'd0);
        check("async_rst_locked", 64'(locked), 64'd0);
        check("async_rst_sof",    64'(sof),    64'd0);
        @(posedge clk); #1;
        reset = 1'b1; k = 0;
        repeat (4) drive(1'b0, 1'b0);
        check("post_rst_slip", 64'(slip), 64'd0);

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
